alarm_ctrl: RTL and testbench



---
 rtl/alarm_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm stage that sits behind the 24-hour BCD time counter.
//
// Holds a user-editable alarm time (HH:MM, BCD). It detects the first
// second of the alarm minute and runs an IDLE/ARMED/RINGING/SNOOZE state
// machine. It drives a beeping buzzer and the alarm digits for the display
// mux.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   tick_1hz                 one-cycle enable, once per second
//   hour_t..sec_o            current time, BCD digits (24 h)
//   set_mode                 level, enables alarm-time editing
//   inc_hour, inc_min        one-cycle pulses, alarm hour/minute +1
//   arm_tgl, snooze, dismiss one-cycle user pulses
//   al_digit3..al_digit0     alarm HH:MM for display
//   armed/ringing/snoozing   state flags
//   buzzer                   beep drive (ringing AND beep phase)
//
// Optional build macro: ALARM_AUTO_STOP_EN. When it is defined, a ring
// that nobody answers returns to ARMED after RING_SEC ticks.
module alarm_ctrl #(
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned INIT_H3    = 0,
    parameter int unsigned INIT_H2    = 7,
    parameter int unsigned INIT_M1    = 0,
    parameter int unsigned INIT_M0    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [3:0] hour_t,
    input  logic [3:0] hour_o,
    input  logic [3:0] min_t,
    input  logic [3:0] min_o,
    input  logic [3:0] sec_t,
    input  logic [3:0] sec_o,
    input  logic       set_mode,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       arm_tgl,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [3:0] al_digit3,
    output logic [3:0] al_digit2,
    output logic [3:0] al_digit1,
    output logic [3:0] al_digit0,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    localparam logic [9:0] SNZ_LAST = 10'(SNOOZE_SEC - 1);
    localparam logic [9:0] SNZ_MAX  = 10'h3FF;

    // BCD hour increment wrapping 23 -> 00
    function automatic logic [7:0] bcd_inc_hour(input logic [3:0] t, input logic [3:0] o);
        logic [7:0] r;
        if (t == 4'd2 && o == 4'd3) begin
            r = 8'h00;
        end else if (o == 4'd9) begin
            r = {t + 4'd1, 4'd0};
        end else begin
            r = {t, o + 4'd1};
        end
        return r;
    endfunction

    // BCD minute increment wrapping 59 -> 00, no carry out
    function automatic logic [7:0] bcd_inc_min(input logic [3:0] t, input logic [3:0] o);
        logic [7:0] r;
        if (o != 4'd9) begin
            r = {t, o + 4'd1};
        end else if (t == 4'd5) begin
            r = 8'h00;
        end else begin
            r = {t + 4'd1, 4'd0};
        end
        return r;
    endfunction

    logic [3:0] al_h3_r, al_h2_r, al_m1_r, al_m0_r;
    logic       eq_now_s, eq_r, match_s;
    state_t     state_r, state_next_s;
    logic       phase_r, phase_next_s;
    logic [9:0] snz_cnt_r, snz_next_s;
    logic       armed_r, ringing_r, snoozing_r, buzzer_r;

`ifdef ALARM_AUTO_STOP_EN
    localparam int unsigned RING_W = (RING_SEC > 64) ? $clog2(RING_SEC) : 6;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
    localparam logic [RING_W-1:0] RING_MAX  = {RING_W{1'b1}};
    logic [RING_W-1:0] ring_cnt_r, ring_next_s;
`else
    // The ring timer does not exist in this build; keep the parameter referenced.
    logic ring_sec_unused_s;
    assign ring_sec_unused_s = (RING_SEC > 0);
`endif

    // Alarm time edit; both digits pairs may step in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            al_h3_r <= 4'(INIT_H3);
            al_h2_r <= 4'(INIT_H2);
            al_m1_r <= 4'(INIT_M1);
            al_m0_r <= 4'(INIT_M0);
        end else if (set_mode) begin
            if (inc_hour) begin
                {al_h3_r, al_h2_r} <= bcd_inc_hour(al_h3_r, al_h2_r);
            end
            if (inc_min) begin
                {al_m1_r, al_m0_r} <= bcd_inc_min(al_m1_r, al_m0_r);
            end
        end
    end

    // Match is the rising edge of equality, so it fires once per alarm minute
    assign eq_now_s = ({hour_t, hour_o, min_t, min_o} == {al_h3_r, al_h2_r, al_m1_r, al_m0_r})
                      && (sec_t == 4'd0) && (sec_o == 4'd0) && !set_mode;
    assign match_s  = eq_now_s && !eq_r;

    // Next-state, beep phase and counter logic; arm_tgl > dismiss > snooze > match/timer
    always_comb begin
        state_next_s = state_r;
        phase_next_s = phase_r;
        snz_next_s   = snz_cnt_r;
`ifdef ALARM_AUTO_STOP_EN
        ring_next_s  = ring_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (arm_tgl) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (arm_tgl) begin
                    state_next_s = ST_IDLE;
                end else if (match_s) begin
                    state_next_s = ST_RINGING;
                    phase_next_s = 1'b1;
`ifdef ALARM_AUTO_STOP_EN
                    ring_next_s  = '0;
`endif
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_RINGING: begin
                if (arm_tgl) begin
                    state_next_s = ST_IDLE;
                end else if (dismiss) begin
                    state_next_s = ST_ARMED;
                end else if (snooze) begin
                    state_next_s = ST_SNOOZE;
                    snz_next_s   = 10'd0;
                end else if (tick_1hz) begin
                    phase_next_s = !phase_r;
`ifdef ALARM_AUTO_STOP_EN
                    if (ring_cnt_r == RING_LAST) begin
                        state_next_s = ST_ARMED;
                    end else if (ring_cnt_r != RING_MAX) begin
                        ring_next_s = ring_cnt_r + RING_W'(1);
                    end else begin
                        ring_next_s = ring_cnt_r;
                    end
`endif
                end else begin
                    state_next_s = ST_RINGING;
                end
            end
            ST_SNOOZE: begin
                if (arm_tgl) begin
                    state_next_s = ST_IDLE;
                end else if (dismiss) begin
                    state_next_s = ST_ARMED;
                end else if (tick_1hz) begin
                    if (snz_cnt_r == SNZ_LAST) begin
                        state_next_s = ST_RINGING;
                        phase_next_s = 1'b1;
`ifdef ALARM_AUTO_STOP_EN
                        ring_next_s  = '0;
`endif
                    end else if (snz_cnt_r != SNZ_MAX) begin
                        snz_next_s = snz_cnt_r + 10'd1;
                    end else begin
                        snz_next_s = snz_cnt_r;
                    end
                end else begin
                    state_next_s = ST_SNOOZE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and output flags; flags are loaded from next state so
    // they line up with the state register with no extra cycle of delay
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            phase_r    <= 1'b1;
            snz_cnt_r  <= 10'd0;
            eq_r       <= 1'b0;
            armed_r    <= 1'b0;
            ringing_r  <= 1'b0;
            snoozing_r <= 1'b0;
            buzzer_r   <= 1'b0;
`ifdef ALARM_AUTO_STOP_EN
            ring_cnt_r <= '0;
`endif
        end else begin
            state_r    <= state_next_s;
            phase_r    <= phase_next_s;
            snz_cnt_r  <= snz_next_s;
            eq_r       <= eq_now_s;
            armed_r    <= (state_next_s != ST_IDLE);
            ringing_r  <= (state_next_s == ST_RINGING);
            snoozing_r <= (state_next_s == ST_SNOOZE);
            buzzer_r   <= (state_next_s == ST_RINGING) && phase_next_s;
`ifdef ALARM_AUTO_STOP_EN
            ring_cnt_r <= ring_next_s;
`endif
        end
    end

    assign al_digit3 = al_h3_r;
    assign al_digit2 = al_h2_r;
    assign al_digit1 = al_m1_r;
    assign al_digit0 = al_m0_r;
    assign armed     = armed_r;
    assign ringing   = ringing_r;
    assign snoozing  = snoozing_r;
    assign buzzer    = buzzer_r;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl: directed stimulus. An integer-based behavioural
// model is compared against the DUT every cycle. Literal checks pin the
// model at key points of the scenario.
module tb_alarm_ctrl;

    localparam int SNOOZE_SEC = 300;
    localparam int RING_SEC   = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_1hz = 1'b0;
    logic [3:0] hour_t = 4'd1, hour_o = 4'd2, min_t = 4'd3, min_o = 4'd4, sec_t = 4'd5, sec_o = 4'd6;
    logic set_mode = 1'b0, inc_hour = 1'b0, inc_min = 1'b0;
    logic arm_tgl = 1'b0, snooze = 1'b0, dismiss = 1'b0;
    logic [3:0] al_digit3, al_digit2, al_digit1, al_digit0;
    logic armed, ringing, snoozing, buzzer;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    alarm_ctrl #(
        .SNOOZE_SEC(SNOOZE_SEC), .RING_SEC(RING_SEC),
        .INIT_H3(0), .INIT_H2(7), .INIT_M1(0), .INIT_M0(0)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .hour_t(hour_t), .hour_o(hour_o), .min_t(min_t), .min_o(min_o),
        .sec_t(sec_t), .sec_o(sec_o),
        .set_mode(set_mode), .inc_hour(inc_hour), .inc_min(inc_min),
        .arm_tgl(arm_tgl), .snooze(snooze), .dismiss(dismiss),
        .al_digit3(al_digit3), .al_digit2(al_digit2), .al_digit1(al_digit1), .al_digit0(al_digit0),
        .armed(armed), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 armed, 2 ringing, 3 snooze; alarm as plain hour/minute
    typedef struct packed {
        int mode;
        int snz;
        int ring;
        bit phase;
        bit prev_eq;
        int ah;
        int am;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t n;
        bit eq, match;
        n = s;
        if (rst) begin
            n.mode = 0; n.snz = 0; n.ring = 0; n.phase = 1'b1; n.prev_eq = 1'b0;
            n.ah = 7; n.am = 0;
            return n;
        end
        eq = (int'(hour_t) * 10 + int'(hour_o) == s.ah) && (int'(min_t) * 10 + int'(min_o) == s.am)
             && sec_t == 4'd0 && sec_o == 4'd0 && !set_mode;
        match = eq && !s.prev_eq;
        n.prev_eq = eq;
        if (set_mode && inc_hour) n.ah = (s.ah + 1) % 24;
        if (set_mode && inc_min)  n.am = (s.am + 1) % 60;
        if (arm_tgl) begin
            n.mode = (s.mode == 0) ? 1 : 0;
        end else if (s.mode == 2 || s.mode == 3) begin
            if (dismiss) n.mode = 1;
            else if (s.mode == 2 && snooze) begin n.mode = 3; n.snz = 0; end
            else if (tick_1hz && s.mode == 2) begin
                n.phase = !s.phase;
                n.ring  = s.ring + 1;
`ifdef ALARM_AUTO_STOP_EN
                if (n.ring == RING_SEC) n.mode = 1;
`endif
            end else if (tick_1hz) begin
                n.snz = s.snz + 1;
                if (n.snz == SNOOZE_SEC) begin n.mode = 2; n.ring = 0; n.phase = 1'b1; end
            end
        end else if (s.mode == 1 && match) begin
            n.mode = 2; n.ring = 0; n.phase = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            check("digit3", 32'(al_digit3), 32'(m.ah / 10));
            check("digit2", 32'(al_digit2), 32'(m.ah % 10));
            check("digit1", 32'(al_digit1), 32'(m.am / 10));
            check("digit0", 32'(al_digit0), 32'(m.am % 10));
            check("armed",    32'(armed),    32'(m.mode != 0));
            check("ringing",  32'(ringing),  32'(m.mode == 2));
            check("snoozing", 32'(snoozing), 32'(m.mode == 3));
            check("buzzer",   32'(buzzer),   32'(m.mode == 2 && m.phase));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        tick_1hz = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;
        arm_tgl = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step();
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        hour_t = 4'(h / 10); hour_o = 4'(h % 10);
        min_t  = 4'(mi / 10); min_o = 4'(mi % 10);
        sec_t  = 4'(s / 10);  sec_o = 4'(s % 10);
    endtask

    task automatic check_digits(input string name, input logic [15:0] exp);
        check(name, 32'({al_digit3, al_digit2, al_digit1, al_digit0}), 32'(exp));
    endtask

    task automatic ring_now();
        set_time(6, 59, 59); step();
        set_time(7, 0, 0);   step();
    endtask

    initial begin
        rst = 1'b1;
        step();
        check_en = 1'b1;
        step();
        rst = 1'b0;
        check_digits("reset_digits", 16'h0700);
        check("reset_armed", 32'(armed), 32'd0);
        check("reset_buzzer", 32'(buzzer), 32'd0);

        // Alarm editing
        set_mode = 1'b1;
        repeat (3)  begin inc_hour = 1'b1; step(); end
        repeat (61) begin inc_min = 1'b1; step(); end
        check_digits("edit_10_01", 16'h1001);
        repeat (13) begin inc_hour = 1'b1; step(); end
        repeat (58) begin inc_min = 1'b1; step(); end
        check_digits("edit_23_59", 16'h2359);
        inc_hour = 1'b1; step();
        check_digits("hour_wrap", 16'h0059);
        inc_min = 1'b1; step();
        check_digits("min_wrap", 16'h0000);
        inc_hour = 1'b1; inc_min = 1'b1; step();
        check_digits("both_inc", 16'h0101);
        repeat (6)  begin inc_hour = 1'b1; step(); end
        repeat (59) begin inc_min = 1'b1; step(); end
        check_digits("edit_07_00", 16'h0700);
        set_mode = 1'b0;
        inc_hour = 1'b1; step();
        check_digits("edit_ignored", 16'h0700);

        // Arm and ring
        arm_tgl = 1'b1; step();
        check("armed_on", 32'(armed), 32'd1);
        set_time(6, 59, 59); step();
        set_time(7, 0, 0);
        check("ring_not_yet", 32'(ringing), 32'd0);
        step();
        check("ring_latency", 32'(ringing), 32'd1);
        check("buzz_1", 32'(buzzer), 32'd1);
        do_tick();
        check("buzz_0", 32'(buzzer), 32'd0);
        do_tick();
        check("buzz_1b", 32'(buzzer), 32'd1);

        // Snooze for SNOOZE_SEC ticks
        snooze = 1'b1; step();
        check("snoozing", 32'(snoozing), 32'd1);
        check("snz_buzz", 32'(buzzer), 32'd0);
        set_time(7, 1, 0);
        repeat (100) do_tick();
        snooze = 1'b1; step();
        repeat (SNOOZE_SEC - 101) do_tick();
        check("snz_299", 32'(snoozing), 32'd1);
        do_tick();
        check("snz_done_ring", 32'(ringing), 32'd1);
        check("snz_done_buzz", 32'(buzzer), 32'd1);
        dismiss = 1'b1; step();
        check("dismiss_armed", 32'(armed), 32'd1);
        check("dismiss_ring", 32'(ringing), 32'd0);

        // No re-trigger inside the same alarm minute
        ring_now();
        check("ring_again", 32'(ringing), 32'd1);
        dismiss = 1'b1; step();
        for (int s = 0; s < 60; s++) begin
            set_time(7, 0, s);
            do_tick();
        end
        check("no_retrigger", 32'(ringing), 32'd0);
        set_time(7, 1, 0); step();
        ring_now();
        check("next_day", 32'(ringing), 32'd1);

        // Simultaneous pulses: arm_tgl wins
        arm_tgl = 1'b1; dismiss = 1'b1; snooze = 1'b1; step();
        check("prio_idle", 32'(armed), 32'd0);

        // Reset during snooze
        arm_tgl = 1'b1; step();
        ring_now();
        snooze = 1'b1; step();
        check("pre_rst_snz", 32'(snoozing), 32'd1);
        set_mode = 1'b1; inc_hour = 1'b1; step();
        set_mode = 1'b0; step();
        check_digits("snz_edit", 16'h0800);
        rst = 1'b1; step();
        rst = 1'b0;
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_snz", 32'(snoozing), 32'd0);
        check_digits("rst_digits", 16'h0700);

        // Ring duration
        arm_tgl = 1'b1; step();
        ring_now();
        check("dur_ring", 32'(ringing), 32'd1);
`ifdef ALARM_AUTO_STOP_EN
        repeat (RING_SEC - 1) do_tick();
        check("auto_59", 32'(ringing), 32'd1);
        do_tick();
        check("auto_stop", 32'(ringing), 32'd0);
        check("auto_armed", 32'(armed), 32'd1);
`else
        repeat (200) do_tick();
        check("ring_200", 32'(ringing), 32'd1);
`endif
        step();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
